// File: rtl/tmul_pkg.sv
// Shared constants and FSM state type for the TMUL tile controller.
package tmul_pkg;
  localparam int unsigned FP16_W = 16;
  localparam int unsigned N_K    = 16;
  localparam int unsigned N_COLS = 32;
  localparam int unsigned ROW_W  = N_COLS * FP16_W;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} tile_state_e;
endpackage

// File: rtl/tmul_res_fifo.sv
// Synchronous result FIFO with registered full/empty flags; head data reads as zero when empty.
module tmul_res_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 513
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             full_q, empty_q;
  logic             do_push, do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign do_push = push && !full_q;
  assign do_pop  = pop && !empty_q;

  always_comb begin
    cnt_d = cnt_q;
    if (do_push && !do_pop) begin
      cnt_d = cnt_q + CW'(1);
    end else if (do_pop && !do_push) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (do_push) wptr_q <= ptr_inc(wptr_q);
      if (do_pop)  rptr_q <= ptr_inc(rptr_q);
      cnt_q   <= cnt_d;
      full_q  <= (cnt_d == CW'(DEPTH));
      empty_q <= (cnt_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata;
  end

  // Gate the head so stale storage never leaks out after reset.
  assign rdata = empty_q ? '0 : mem_q[rptr_q];
  assign empty = empty_q;
endmodule

// File: rtl/tmul_tile_ctrl.sv
// Tile controller: credit-gated A-row issue, skewed feed into the FMA row, and result buffering.
module tmul_tile_ctrl #(
  parameter int unsigned N_K        = tmul_pkg::N_K,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [4:0]                       rows_cfg,
  output logic                             busy,
  output logic                             done,
  input  logic                             a_valid,
  output logic                             a_ready,
  input  logic [N_K*tmul_pkg::FP16_W-1:0]  a_row,
  output logic [N_K*tmul_pkg::FP16_W-1:0]  stage_a,
  input  logic [tmul_pkg::ROW_W-1:0]       pipe_res,
  output logic                             res_valid,
  input  logic                             res_ready,
  output logic [tmul_pkg::ROW_W-1:0]       res_data,
  output logic                             res_last
);
  import tmul_pkg::*;

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  tile_state_e   state_q, state_d;
  logic [4:0]    rows_q, rows_d;
  logic [4:0]    issued_q, issued_d;
  logic [4:0]    cap_q, cap_d;
  logic [CW-1:0] credit_q, credit_d;
  logic [N_K-1:0] vld_q;
  logic          accept, capture, pop, cap_last, fifo_empty;

  assign accept   = a_valid && a_ready;
  assign capture  = vld_q[N_K-1];
  assign pop      = res_valid && res_ready;
  assign cap_last = (cap_q == rows_q - 5'd1);

  assign busy    = (state_q != StIdle);
  assign done    = (state_q == StDone);
  assign a_ready = (state_q == StRun) && (issued_q < rows_q) && (credit_q != '0);

  always_comb begin
    state_d  = state_q;
    rows_d   = rows_q;
    issued_d = issued_q;
    cap_d    = cap_q;
    credit_d = credit_q;
    if (accept)  issued_d = issued_q + 5'd1;
    if (capture) cap_d = cap_q + 5'd1;
    // Credit mirrors free FIFO slots including rows still inside the datapath.
    if (accept && !pop) begin
      credit_d = credit_q - CW'(1);
    end else if (pop && !accept) begin
      credit_d = credit_q + CW'(1);
    end
    unique case (state_q)
      StIdle: begin
        if (start) begin
          rows_d   = rows_cfg;
          issued_d = '0;
          cap_d    = '0;
          state_d  = (rows_cfg == 5'd0) ? StDone : StRun;
        end
      end
      StRun:   if (accept && (issued_d == rows_q)) state_d = StDrain;
      StDrain: if (pop && res_last) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      rows_q   <= '0;
      issued_q <= '0;
      cap_q    <= '0;
      credit_q <= CW'(FIFO_DEPTH);
      vld_q    <= '0;
    end else begin
      state_q  <= state_d;
      rows_q   <= rows_d;
      issued_q <= issued_d;
      cap_q    <= cap_d;
      credit_q <= credit_d;
      vld_q    <= {vld_q[N_K-2:0], accept};
    end
  end

  // Element k rides a k+1 deep chain; zeros enter whenever no row is accepted.
  for (genvar k = 0; k < N_K; k++) begin : g_skew
    logic [FP16_W-1:0] dly_q [k+1];
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int j = 0; j <= k; j++) dly_q[j] <= '0;
      end else begin
        dly_q[0] <= accept ? a_row[k*FP16_W +: FP16_W] : '0;
        for (int j = 1; j <= k; j++) dly_q[j] <= dly_q[j-1];
      end
    end
    assign stage_a[k*FP16_W +: FP16_W] = dly_q[k];
  end

  tmul_res_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ROW_W + 1)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (capture),
    .wdata ({cap_last, pipe_res}),
    .pop   (pop),
    .rdata ({res_last, res_data}),
    .empty (fifo_empty)
  );

  assign res_valid = !fifo_empty;
endmodule

// File: tb/tb_tmul_tile_ctrl.sv
// Scoreboard bench for tmul_tile_ctrl: accepted rows queue expected results, a monitor checks pops.
module tb_tmul_tile_ctrl;
  localparam int unsigned K = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Datapath stand-in: the result word encodes the cycle it was sampled in.
  logic [511:0] pipe_res;
  assign pipe_res = {16{cyc}};

  logic         start, a_valid, a_ready, busy, done, res_valid, res_ready, res_last;
  logic [4:0]   rows_cfg;
  logic [255:0] a_row, stage_a;
  logic [511:0] res_data;

  logic         start4, a_valid4, a_ready4, busy4, done4, res_valid4, res_ready4, res_last4;
  logic [4:0]   rows_cfg4;
  logic [255:0] stage_a4;
  logic [511:0] res_data4;

  tmul_tile_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .rows_cfg(rows_cfg), .busy(busy), .done(done),
    .a_valid(a_valid), .a_ready(a_ready), .a_row(a_row), .stage_a(stage_a),
    .pipe_res(pipe_res), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_last(res_last)
  );

  tmul_tile_ctrl #(.N_K(16), .FIFO_DEPTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .rows_cfg(rows_cfg4), .busy(busy4), .done(done4),
    .a_valid(a_valid4), .a_ready(a_ready4), .a_row(a_row), .stage_a(stage_a4),
    .pipe_res(pipe_res), .res_valid(res_valid4), .res_ready(res_ready4),
    .res_data(res_data4), .res_last(res_last4)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic [512:0] exp_q[$];
  logic [512:0] exp_e;
  int row_idx = 0;
  int tb_rows = 0;
  int n_acc = 0;
  int acc4 = 0;
  int pops4 = 0;

  // Stimulus side of the scoreboard: each accepted row expects its result N_K cycles later.
  always @(negedge clk) begin
    if (!rst && a_valid && a_ready) begin
      exp_q.push_back({(row_idx == tb_rows - 1), {16{cyc + 32'd16}}});
      row_idx++;
      n_acc++;
    end
    if (!rst && a_valid4 && a_ready4) acc4++;
  end

  // Monitor: compare every popped result against the queue head.
  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got %0h expected none", res_data);
      end else begin
        exp_e = exp_q.pop_front();
        chk("res_data", res_data, exp_e[511:0]);
        chk("res_last", res_last, exp_e[512]);
      end
    end
    if (!rst && res_valid4 && res_ready4) begin
      chk("dut4_res_last", res_last4, pops4 == 7);
      pops4++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int rows);
    tb_rows  = rows;
    row_idx  = 0;
    start    = 1'b1;
    rows_cfg = rows[4:0];
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < budget);
    chk(name, done, 1'b1);
    tick();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_a_ready"}, a_ready, 1'b0);
    chk({tag, "_res_valid"}, res_valid, 1'b0);
    chk({tag, "_res_last"}, res_last, 1'b0);
    chk({tag, "_res_data"}, res_data, '0);
    chk({tag, "_stage_a"}, stage_a, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  logic [255:0] exp_sa;
  int seen;

  initial begin
    rst = 1'b1; start = 1'b0; rows_cfg = '0; a_valid = 1'b0; a_row = '0; res_ready = 1'b0;
    start4 = 1'b0; rows_cfg4 = '0; a_valid4 = 1'b0; res_ready4 = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_reset_outputs("reset");
    tick();

    // Single row with skew probe: element k carries k+1.
    for (int k = 0; k < K; k++) a_row[16*k +: 16] = 16'(k + 1);
    res_ready = 1'b1;
    a_valid   = 1'b1;
    do_start(1);
    @(negedge clk);
    chk("single_a_ready", a_ready, 1'b1);
    tick();
    a_valid = 1'b0;
    for (int i = 1; i <= 18; i++) begin
      @(negedge clk);
      exp_sa = '0;
      if (i <= K) exp_sa[16*(i-1) +: 16] = 16'(i);
      chk("stage_a_skew", stage_a, exp_sa);
      chk("res_valid_latency", res_valid, i == 17);
      chk("done_after_pop", done, i == 18);
    end
    tick();

    // Full tile, no backpressure.
    a_valid = 1'b1;
    n_acc   = 0;
    do_start(16);
    for (int j = 0; j < 18; j++) begin
      @(negedge clk);
      chk("full_a_ready", a_ready, j < 16);
    end
    tick();
    a_valid = 1'b0;
    wait_done("full_done", 40);
    chk("full_accepts", n_acc, 16);
    chk("full_sb_empty", exp_q.size(), 0);

    // Backpressure: buffer all 16 then release.
    res_ready = 1'b0;
    a_valid   = 1'b1;
    n_acc     = 0;
    do_start(16);
    repeat (40) @(negedge clk);
    chk("bp_accepts", n_acc, 16);
    chk("bp_a_ready_low", a_ready, 1'b0);
    chk("bp_res_valid", res_valid, 1'b1);
    chk("bp_sb_pending", exp_q.size(), 16);
    tick();
    a_valid   = 1'b0;
    res_ready = 1'b1;
    wait_done("bp_done", 40);
    chk("bp_sb_empty", exp_q.size(), 0);

    // Reset five cycles into RUN discards everything.
    a_valid = 1'b1;
    do_start(16);
    repeat (5) tick();
    rst     = 1'b1;
    a_valid = 1'b0;
    exp_q.delete();
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk_reset_outputs("midrst");
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (res_valid || busy) seen++;
    end
    chk("midrst_quiet", seen, 0);
    tick();

    // Start while busy is ignored.
    a_valid = 1'b0;
    n_acc   = 0;
    do_start(2);
    rows_cfg = 5'd5;
    start    = 1'b1;
    tick();
    start   = 1'b0;
    a_valid = 1'b1;
    repeat (10) tick();
    a_valid = 1'b0;
    wait_done("busy_start_done", 40);
    chk("busy_start_accepts", n_acc, 2);
    @(negedge clk);
    chk("busy_start_idle", busy, 1'b0);
    tick();

    // Zero-row tile goes straight to DONE.
    a_valid  = 1'b1;
    n_acc    = 0;
    tb_rows  = 0;
    start    = 1'b1;
    rows_cfg = 5'd0;
    @(negedge clk);
    chk("zero_c0_done", done, 1'b0);
    chk("zero_c0_a_ready", a_ready, 1'b0);
    tick();
    start = 1'b0;
    @(negedge clk);
    chk("zero_c1_done", done, 1'b1);
    chk("zero_c1_busy", busy, 1'b1);
    chk("zero_c1_a_ready", a_ready, 1'b0);
    tick();
    @(negedge clk);
    chk("zero_c2_done", done, 1'b0);
    chk("zero_c2_busy", busy, 1'b0);
    chk("zero_accepts", n_acc, 0);
    tick();
    a_valid = 1'b0;

    // Credit boundary on the 4-deep instance.
    a_valid4   = 1'b1;
    res_ready4 = 1'b0;
    start4     = 1'b1;
    rows_cfg4  = 5'd8;
    tick();
    start4 = 1'b0;
    repeat (30) @(negedge clk);
    chk("credit_stall_accepts", acc4, 4);
    chk("credit_stall_a_ready", a_ready4, 1'b0);
    chk("credit_stall_res_valid", res_valid4, 1'b1);
    for (int p = 0; p < 2; p++) begin
      tick();
      res_ready4 = 1'b1;
      tick();
      res_ready4 = 1'b0;
      repeat (6) @(negedge clk);
      chk("credit_one_per_pop", acc4, 5 + p);
    end
    tick();
    res_ready4 = 1'b1;
    seen = 0;
    for (int n = 0; n < 80 && seen == 0; n++) begin
      @(negedge clk);
      if (done4) seen = 1;
    end
    chk("credit_done", seen, 1);
    chk("credit_total_accepts", acc4, 8);
    chk("credit_total_pops", pops4, 8);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/tmul_tile_ctrl.md
TMUL_TILE_CTRL -- requirements
Module: tmul_tile_ctrl

Interface
REQ-001 SHALL have parameter N_K, default 16: number of FMA row stages (A elements per row).
REQ-002 SHALL have parameter FIFO_DEPTH, default 16: result buffer entries, also the issue-credit count.
REQ-003 SHALL have port clk  input  1: clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1: reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1: begin a tile; sampled only in IDLE.
REQ-006 SHALL have port rows_cfg  input  5: number of A rows in the tile, 0..16; captured on accepted start.
REQ-007 SHALL have port busy  output  1: high whenever state is not IDLE.
REQ-008 SHALL have port done  output  1: single-cycle pulse at tile completion.
REQ-009 SHALL have ports a_valid in 1, a_ready out 1, a_row in 256: A-row input handshake, 16 FP16 elements, element k in bits [16k+15:16k].
REQ-010 SHALL have port stage_a  output  256: skewed A elements driving the datapath RowA port, element k feeding stage k.
REQ-011 SHALL have port pipe_res  input  512: combinational result of final datapath stage.
REQ-012 SHALL have ports res_valid out 1, res_ready in 1, res_data out 512, res_last out 1: result output handshake.

Function
REQ-013 SHALL implement FSM IDLE -> RUN on start; RUN -> DRAIN when rows_cfg rows accepted; DRAIN -> DONE when last result popped; DONE -> IDLE after one cycle; IDLE -> DONE directly when start with rows_cfg==0.
REQ-014 SHALL ignore start while not in IDLE.
REQ-015 SHALL drive a_ready = (state==RUN) && (issued < rows_cfg) && (credit != 0); transfer occurs when a_valid && a_ready.
REQ-016 SHALL present element k of an accepted row on stage_a element k exactly k+1 cycles after the accept edge, via per-element delay registers.
REQ-017 SHALL drive stage_a elements with no valid in flight to zero.
REQ-018 SHALL track in-flight rows with an N_K-bit valid shift register; bit 0 set the cycle after accept; result sampled into the FIFO at the edge where bit N_K-1 is high (accept + N_K cycles).
REQ-019 SHALL tag each FIFO entry with last = (row index == rows_cfg-1) and drive res_last from the head entry.
REQ-020 SHALL assert res_valid when FIFO non-empty; first res_valid 17 cycles after accept with empty FIFO (N_K=16).
REQ-021 SHALL initialise credit to FIFO_DEPTH; decrement on accept, increment on pop; simultaneous accept and pop leave it unchanged; credit never exceeds FIFO_DEPTH nor underflows.
REQ-022 SHALL never drop a result: credit guarantees FIFO space at every capture, since the datapath cannot stall.
REQ-023 SHALL pulse done in DONE state, i.e. the cycle after the res_last pop, or the cycle after start for rows_cfg==0.
REQ-024 SHALL preserve result order equal to acceptance order.

Reset
REQ-025 SHALL on rst: state IDLE, busy 0, done 0, a_ready 0, res_valid 0, res_last 0, res_data 0, stage_a 0, credit FIFO_DEPTH, valid shift register, issue counter and FIFO cleared.
REQ-026 SHALL discard all in-flight and buffered results when rst asserts mid-tile; no res_valid until a new tile's results arrive.

Structure
REQ-027 SHALL take FP16_W=16, N_K=16, N_COLS=32, ROW_W=512 and the FSM state enum from shared package tmul_pkg.
REQ-028 SHALL instantiate one sub-module tmul_res_fifo: synchronous FIFO, FIFO_DEPTH x 513 bits (data+last), registered flags.

Verification
REQ-029 SHALL cover single row: rows_cfg=1, accept at cycle 0 -> res_valid at cycle 17, res_last=1, done one cycle after pop.
REQ-030 SHALL cover skew: a_row element k = k+1 -> stage_a element k equals k+1 only at accept+1+k, zero otherwise.
REQ-031 SHALL cover full tile with res_ready=1: rows_cfg=16 -> a_ready high 16 consecutive cycles, 16 consecutive results, res_last on the 16th only.
REQ-032 SHALL cover backpressure: res_ready=0, rows_cfg=16 -> 16 accepts, a_ready then 0, FIFO full; releasing res_ready yields all 16 in order.
REQ-033 SHALL cover credit boundary with FIFO_DEPTH=4 and rows_cfg=8, res_ready=0 -> exactly 4 accepts; each pop enables exactly one further accept.
REQ-034 SHALL cover reset at RUN cycle 5, start while busy, and rows_cfg=0 -> IDLE with all outputs at reset values; start ignored; done at cycle 1 with no a_ready.
